// File: rtl/openlab_pkg.sv
// Shared board-level constants for the OpenLab Nios II system.
// Derives debounce windows from the system clock rate.
package openlab_pkg;

   localparam int CLK_HZ      = 32'd50_000_000;
   localparam int DEBOUNCE_MS = 32'd10;

   // Number of CLK_HZ cycles spanning the given number of milliseconds.
   function automatic int cycles_from_ms(input int ms);
      return (CLK_HZ / 32'd1000) * ms;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, debounced value
// and registered single-cycle rise/fall pulses.
module debounce_bit
   import openlab_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = cycles_from_ms(DEBOUNCE_MS)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int CW = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 32'd1);

   logic          sync_meta_r;
   logic          sync_r;
   logic [CW-1:0] cnt_r;
   logic          stable_r;
   logic          rise_r;
   logic          fall_r;

   logic [CW-1:0] cnt_nxt_s;
   logic          stable_nxt_s;
   logic          rise_nxt_s;
   logic          fall_nxt_s;

   // Synchroniser: the first flop may go metastable, only sync_r is used.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta_r <= 1'b0;
         sync_r      <= 1'b0;
      end else begin
         sync_meta_r <= pin;
         sync_r      <= sync_meta_r;
      end
   end

   // Count consecutive disagreeing cycles; any agreeing cycle restarts.
   always_comb begin
      cnt_nxt_s    = cnt_r;
      stable_nxt_s = stable_r;
      rise_nxt_s   = 1'b0;
      fall_nxt_s   = 1'b0;
      if (sync_r == stable_r) begin
         cnt_nxt_s = '0;
      end else if (cnt_r == CNT_MAX) begin
         cnt_nxt_s    = '0;
         stable_nxt_s = sync_r;
         rise_nxt_s   = sync_r;
         fall_nxt_s   = ~sync_r;
      end else begin
         cnt_nxt_s = cnt_r + CW'(1);
      end
   end

   // Counter, debounced value and edge pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= '0;
         stable_r <= 1'b0;
         rise_r   <= 1'b0;
         fall_r   <= 1'b0;
      end else begin
         cnt_r    <= cnt_nxt_s;
         stable_r <= stable_nxt_s;
         rise_r   <= rise_nxt_s;
         fall_r   <= fall_nxt_s;
      end
   end

   assign stable = stable_r;
   assign rise   = rise_r;
   assign fall   = fall_r;

endmodule

// File: rtl/switch_debounce.sv
// Debounces the slide switches for the switches PIO and raises a sticky
// change flag that software clears with irq_clr.
module switch_debounce
   import openlab_pkg::*;
#(
   parameter int WIDTH           = 32'd8,
   parameter int DEBOUNCE_CYCLES = cycles_from_ms(DEBOUNCE_MS)
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   input  logic             irq_clr,
   output logic [WIDTH-1:0] sw_stable,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             irq
);

   logic irq_r;
   logic irq_nxt_s;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
         .clk   (clk_clk),
         .rst_n (reset_reset_n),
         .pin   (sw_raw[i]),
         .stable(sw_stable[i]),
         .rise  (sw_rise[i]),
         .fall  (sw_fall[i])
      );
   end

   // Sticky change flag; a new change beats a simultaneous clear.
   always_comb begin
      irq_nxt_s = irq_r;
      if (|(sw_rise | sw_fall)) begin
         irq_nxt_s = 1'b1;
      end else if (irq_clr) begin
         irq_nxt_s = 1'b0;
      end else begin
         irq_nxt_s = irq_r;
      end
   end

   // Interrupt flag register.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= irq_nxt_s;
      end
   end

   assign irq = irq_r;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with DEBOUNCE_CYCLES=4: a window-based
// reference model predicts outputs per edge, a monitor compares them.
module tb_switch_debounce;

   localparam int W  = 8;
   localparam int DC = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] sw_raw;
   logic         clr;
   logic [W-1:0] sw_stable;
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
   logic         irq;

   switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
      .clk_clk      (clk),
      .reset_reset_n(rst_n),
      .sw_raw       (sw_raw),
      .irq_clr      (clr),
      .sw_stable    (sw_stable),
      .sw_rise      (sw_rise),
      .sw_fall      (sw_fall),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] st;
      logic [W-1:0] ri;
      logic [W-1:0] fa;
      logic         irq;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // Reference model: pin samples in order; the value seen by the stability
   // check at an edge is the pin sampled two edges earlier.
   logic [W-1:0] hist[$];
   logic [W-1:0] m_st, m_ri, m_fa;
   logic         m_irq;

   task automatic model_reset();
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      m_st  = '0;
      m_ri  = '0;
      m_fa  = '0;
      m_irq = 1'b0;
   endtask

   task automatic model_edge(input logic [W-1:0] pin, input logic c);
      logic [W-1:0] new_st;
      logic         all_diff;
      m_irq = (|(m_ri | m_fa)) ? 1'b1 : (c ? 1'b0 : m_irq);
      hist.push_back(pin);
      new_st = m_st;
      if (hist.size() - 2 >= DC) begin
         for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DC; k++)
               if (hist[hist.size() - 3 - k][b] == m_st[b]) all_diff = 1'b0;
            if (all_diff) new_st[b] = ~m_st[b];
         end
      end
      m_ri = new_st & ~m_st;
      m_fa = ~new_st & m_st;
      m_st = new_st;
      while (hist.size() > DC + 4) void'(hist.pop_front());
   endtask

   task automatic step(input logic r, input logic [W-1:0] sw, input logic c);
      exp_t e;
      @(negedge clk);
      rst_n  = r;
      sw_raw = sw;
      clr    = c;
      @(posedge clk);
      if (!r) model_reset();
      else    model_edge(sw, c);
      e.st  = m_st;
      e.ri  = m_ri;
      e.fa  = m_fa;
      e.irq = m_irq;
      exp_q.push_back(e);
   endtask

   task automatic hold(input logic r, input logic [W-1:0] sw, input logic c, input int n);
      for (int i = 0; i < n; i++) step(r, sw, c);
   endtask

   task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sw_stable", sw_stable, e.st);
            chk("sw_rise",   sw_rise,   e.ri);
            chk("sw_fall",   sw_fall,   e.fa);
            chk("irq",       {7'd0, irq}, {7'd0, e.irq});
         end
      end
   end

   initial begin
      logic [W-1:0] cur;
      int           p;
      rst_n  = 1'b0;
      sw_raw = '0;
      clr    = 1'b0;
      model_reset();

      // Switches held through reset, then accepted as a power-up change.
      hold(1'b0, 8'hA5, 1'b0, 3);
      hold(1'b1, 8'hA5, 1'b0, 9);
      // Software clear.
      step(1'b1, 8'hA5, 1'b1);
      hold(1'b1, 8'hA5, 1'b0, 3);

      // Clean single-bit change.
      hold(1'b0, 8'h00, 1'b0, 2);
      hold(1'b1, 8'h00, 1'b0, 3);
      hold(1'b1, 8'h01, 1'b0, 9);

      // Bounce on bit 3 never reaches the output.
      for (int r = 0; r < 2; r++) begin
         hold(1'b1, 8'h09, 1'b0, 3);
         step(1'b1, 8'h01, 1'b0);
      end
      hold(1'b1, 8'h01, 1'b0, 6);

      // All bits at once, then the upper nibble falls together.
      hold(1'b0, 8'h00, 1'b0, 2);
      hold(1'b1, 8'h00, 1'b0, 2);
      hold(1'b1, 8'hFF, 1'b0, 9);
      hold(1'b1, 8'h0F, 1'b0, 9);
      step(1'b1, 8'h0F, 1'b1);
      hold(1'b1, 8'h0F, 1'b0, 2);

      // Clear held high while bit 1 rises: set beats clear.
      hold(1'b1, 8'h0D, 1'b0, 9);
      step(1'b1, 8'h0D, 1'b1);
      hold(1'b1, 8'h0F, 1'b1, 9);
      hold(1'b1, 8'h0F, 1'b0, 2);

      // Reset while bit 2 is part-way through its count.
      hold(1'b0, 8'h00, 1'b0, 2);
      hold(1'b1, 8'h00, 1'b0, 3);
      hold(1'b1, 8'h04, 1'b0, 4);
      hold(1'b0, 8'h04, 1'b0, 2);
      hold(1'b1, 8'h04, 1'b0, 9);

      // Randomised switch activity with varying bounce rates.
      cur = '0;
      for (int blk = 0; blk < 24; blk++) begin
         p = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 8 : 30);
         for (int i = 0; i < 25; i++) begin
            for (int b = 0; b < W; b++)
               if ($urandom_range(p - 1) == 0) cur[b] = ~cur[b];
            step(($urandom_range(199) != 0), cur, ($urandom_range(7) == 0));
         end
      end

      repeat (3) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain cyc=%0d got=%0d want=0 pending", cyc, exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
